// File: rtl/arb_req_queue.sv
// arb_req_queue: per-requester FIFO stage in front of a round-robin arbiter.
// Each of N channels buffers its valid/ready stream in a DEPTH-entry FIFO.
// Non-empty FIFOs raise req while the output register can take an entry.
// The granted head is moved into a single registered valid/ready output.
// Optional feature macro: ARB_REQ_QUEUE_CNT_EN adds per-channel 16-bit
// saturating grant counters on output port grant_cnt.
module arb_req_queue #(
    parameter int N     = 16,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N-1:0]                    in_valid,
    input  logic [N*DW-1:0]                 in_data,
    output logic [N-1:0]                    in_ready,
    output logic [N-1:0]                    req,
    input  logic [N-1:0]                    grant,
`ifdef ARB_REQ_QUEUE_CNT_EN
    output logic [N*16-1:0]                 grant_cnt,
`endif
    output logic                            out_valid,
    output logic [DW-1:0]                   out_data,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_src,
    input  logic                            out_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] mem_r    [N][DEPTH];
    logic [PW-1:0] wr_ptr_r [N];
    logic [PW-1:0] rd_ptr_r [N];

    logic [N-1:0]  full_s;
    logic [N-1:0]  empty_s;
    logic [N-1:0]  push_s;
    logic [N-1:0]  pop_s;
    logic [N-1:0]  eff_grant_s;
    logic          out_free_s;
    logic          sel_valid_s;
    logic [SW-1:0] sel_idx_s;
    logic [DW-1:0] head_data_s;

    logic          out_valid_r;
    logic [DW-1:0] out_data_r;
    logic [SW-1:0] out_src_r;

    // FIFO status flags, handshakes and the request vector seen by the arbiter
    always_comb begin
        full_s      = '0;
        empty_s     = '0;
        push_s      = '0;
        out_free_s  = !out_valid_r || out_ready;
        for (int i = 0; i < N; i++) begin
            empty_s[i] = (wr_ptr_r[i] == rd_ptr_r[i]);
            full_s[i]  = (wr_ptr_r[i][AW] != rd_ptr_r[i][AW]) &&
                         (wr_ptr_r[i][AW-1:0] == rd_ptr_r[i][AW-1:0]);
            // no pass-through: a full FIFO refuses a push even while being popped
            push_s[i]  = in_valid[i] && !full_s[i];
        end
        in_ready    = ~full_s;
        req         = ~empty_s & {N{out_free_s}};
        eff_grant_s = grant & req;
    end

    // Resolve the effective grant to a single channel; lowest index wins if illegal
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        pop_s       = '0;
        for (int i = 0; i < N; i++) begin
            if (eff_grant_s[i] && !sel_valid_s) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = SW'(i);
            end else begin
                sel_valid_s = sel_valid_s;
            end
        end
        for (int i = 0; i < N; i++) begin
            pop_s[i] = sel_valid_s && (sel_idx_s == SW'(i));
        end
        head_data_s = mem_r[sel_idx_s][rd_ptr_r[sel_idx_s][AW-1:0]];
    end

    // FIFO payload storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push_s[i]) begin
                mem_r[i][wr_ptr_r[i][AW-1:0]] <= in_data[i*DW +: DW];
            end
        end
    end

    // FIFO read/write pointers, wrapping modulo 2*DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push_s[i]) begin
                    wr_ptr_r[i] <= wr_ptr_r[i] + PW'(1);
                end
                if (pop_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PW'(1);
                end
            end
        end
    end

    // Output register: load the granted head when free, otherwise hold
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_src_r   <= '0;
        end else if (out_free_s) begin
            if (sel_valid_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= head_data_s;
                out_src_r   <= sel_idx_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_src   = out_src_r;

`ifdef ARB_REQ_QUEUE_CNT_EN
    logic [15:0] cnt_r [N];

    // Per-channel saturating count of effective grants
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                cnt_r[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (eff_grant_s[i] && (cnt_r[i] != 16'hFFFF)) begin
                    cnt_r[i] <= cnt_r[i] + 16'h0001;
                end
            end
        end
    end

    // Flatten counters onto the output bus
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < N; i++) begin
            grant_cnt[i*16 +: 16] = cnt_r[i];
        end
    end
`endif

endmodule

// File: doc/arb_req_queue.md
# arb_req_queue

Per-requester input queue stage that sits directly upstream of the round-robin arbiter. It accepts up to N independent valid/ready request streams and buffers each in its own small FIFO. It drives the arbiter's `req` vector from FIFO occupancy, takes the arbiter's one-hot `grant` back, and moves the granted entry into a single registered output with valid/ready.

## Interface
- `N`, 16: number of requester channels.
- `DW`, 32: payload width per request.
- `DEPTH`, 4: entries per channel FIFO; a power of two, at least 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `in_valid` in N: per-channel request valid.
- `in_data` in N*DW: per-channel payload; channel i occupies bits [i*DW +: DW].
- `in_ready` out N: per-channel ready; a push happens when `in_valid[i] & in_ready[i]`.
- `req` out N: request vector to the arbiter.
- `grant` in N: one-hot grant from the arbiter, combinational on `req` in the same cycle.
- `out_valid` out 1: output register holds a valid entry.
- `out_data` out DW: payload of the output entry.
- `out_src` out $clog2(N): channel index the output entry came from.
- `out_ready` in 1: downstream accept; a pop happens when `out_valid & out_ready`.

## Operation
- Each channel has a FIFO with DEPTH entries. It uses read/write pointers of $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty, and pointers wrap modulo 2*DEPTH.
- `in_ready[i]` = channel i FIFO not full. There is no pass-through: a full FIFO does not accept a push even in a cycle where it is also popped.
- Output stage is free when `!out_valid | out_ready`.
- `req[i]` = FIFO i not empty AND output stage free. When the output stage is stalled, `req` is all zeros, so the arbiter pointer does not advance.
- Effective grant = `grant & req`. Bits outside `req` are ignored.
- If the effective grant has more than one bit set (illegal), the lowest set index wins. No other channel is popped.
- When the effective grant is nonzero for channel k:
  - Pop the head of FIFO k.
  - Load `out_data` with that head entry and `out_src` with k.
  - Set `out_valid` to 1.
- When the output stage is free and the effective grant is zero, `out_valid` goes to 0. `out_data` and `out_src` hold their values.
- Push and pop on the same channel in the same cycle are both allowed when not full; occupancy is unchanged.
- Each channel preserves its own order. Order across channels is decided only by the arbiter.

## Timing
- Reset (`rst_n`=0 at a clock edge):
  - All FIFOs empty.
  - `out_valid`=0, `out_data`=0, `out_src`=0.
  - Therefore `req`=0 and `in_ready`=all ones in the first cycle after reset.
- Reset applied mid-operation discards all buffered entries and the output entry. It does not wait for outstanding handshakes.
- Latency: a push at edge t makes `req[i]`=1 in cycle t+1 (if the output stage is free). A grant in cycle t+1 gives `out_valid`=1 after edge t+2. Minimum push-to-output is 2 cycles.
- Throughput: one entry per cycle sustained while `out_ready`=1.
- A push into a channel that is also being popped becomes visible in the next cycle. There is no combinational path from `in_valid` to `req`.
- `req` depends combinationally on `out_valid` and `out_ready`. `grant` is allowed to be combinational on `req`. There is no combinational path from `grant` to `req`.

## Configuration
- `ARB_REQ_QUEUE_CNT_EN` defined:
  - Adds output port `grant_cnt` (out, N*16). Channel i is bits [i*16 +: 16].
  - Each 16-bit counter increments on every effective grant to its channel and saturates at 16'hFFFF.
  - Counters reset to 0 on `rst_n`.
- Macro undefined:
  - Port and counters are absent.
  - All other behaviour is identical.

## Test plan
- Reset, then push 0xA0 on ch3 only with `out_ready`=1 and the arbiter granting lowest index:
  - `req`=16'h0008 in the cycle after the push.
  - `out_valid`=1, `out_data`=0xA0, `out_src`=3 two cycles after the push.
  - `req`=0 afterwards.
- Push 5 entries back-to-back into ch0 (DEPTH=4) with `grant` held at 0: `in_ready[0]` drops to 0 after the 4th push, and the 5th is not accepted. Then grant 4 times: data comes out in order 0..3, and `in_ready[0]` returns to 1 after the first pop.
- Fill ch1 and ch2 with 2 entries each, then hold `out_ready`=0 for 3 cycles after the first output:
  - `req`=0 and `out_data` stable while stalled.
  - After release, the remaining 3 entries drain at one per cycle.
- Drive an illegal `grant`=16'h0006 with `req`=16'h0006: only ch1 pops, and `out_src`=1.
- Drive `grant`=16'h0010 while `req`=16'h0001: no pop, and `out_valid` goes to 0.
- Assert `rst_n`=0 for one cycle while ch0 holds 3 entries and `out_valid`=1:
  - Next cycle `out_valid`=0, `req`=0, and `in_ready`=all ones.
  - With `ARB_REQ_QUEUE_CNT_EN` defined, `grant_cnt`=0.
